// File: rtl/mips16_multicycle_core.sv
// ---------------------------------------------------------------------------
// mips16_multicycle_core
//
// Multi-cycle 16-bit MIPS-style core. An FSM steps each instruction through
// FETCH -> DECODE -> EXEC -> MEM -> WB. Instruction and data memories sit
// behind req/ack handshakes, so they may take any number of cycles to respond.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   imem_req/addr/ack/rdata   instruction fetch handshake (addr = pc)
//   dmem_req/we/addr/wdata    data access request (held until dmem_ack)
//   dmem_ack/rdata            data access completion; rdata valid for loads
//   pc                        current program counter (byte address)
//   alu_out                   registered ALU result of the last EXEC
//   retire                    one-cycle pulse per completed instruction
//   halted                    high while in the HALT state
// ---------------------------------------------------------------------------
module mips16_multicycle_core #(
    parameter int DATA_W  = 16,
    parameter int PC_W    = 16,
    parameter int DADDR_W = 6,
    parameter bit R0_ZERO = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [15:0]        imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic               dmem_ack,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic [PC_W-1:0]    pc,
    output logic [DATA_W-1:0]  alu_out,
    output logic               retire,
    output logic               halted
);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_LW   = 4'h3;
    localparam logic [3:0] OP_SW   = 4'h4;
    localparam logic [3:0] OP_J    = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_AND  = 4'h9;
    localparam logic [3:0] OP_SLT  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       ir_q, ir_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              retire_q, retire_d;
    logic [DATA_W-1:0] rf_q [16];
    logic [DATA_W-1:0] rf_d [16];

    // ------------------------------------------------------------------
    // Instruction decode (always from the latched IR)
    // ------------------------------------------------------------------
    logic [3:0]        op;
    logic              is_nop, is_lw, is_sw, is_j, is_beq, is_halt, use_imm;
    logic [3:0]        rs_idx, rt_idx, rd_idx;
    logic [DATA_W-1:0] imm_ext;
    logic [PC_W-1:0]   br_off;
    logic [PC_W-1:0]   jmp_target;
    logic [DATA_W-1:0] rs_val, rt_val;
    logic [DATA_W-1:0] alu_b, alu_res;
    logic              rf_we;

    assign op      = ir_q[15:12];
    assign is_nop  = op inside {4'hB, 4'hC, 4'hD, 4'hE};
    assign is_lw   = (op == OP_LW);
    assign is_sw   = (op == OP_SW);
    assign is_j    = (op == OP_J);
    assign is_beq  = (op == OP_BEQ);
    assign is_halt = (op == OP_HALT);
    assign use_imm = (op == OP_ADDI) || is_lw || is_sw;

    // BEQ compares [11:8] with [7:4]; SW stores the register in [11:8].
    assign rs_idx = is_beq ? ir_q[11:8] : ir_q[7:4];
    assign rt_idx = is_sw  ? ir_q[11:8] : (is_beq ? ir_q[7:4] : ir_q[3:0]);
    assign rd_idx = ir_q[11:8];

    assign imm_ext    = {{(DATA_W-4){ir_q[3]}}, ir_q[3:0]};
    // Branch offset counts instructions, so it is scaled to bytes here.
    assign br_off     = {{(PC_W-5){ir_q[3]}}, ir_q[3:0], 1'b0};
    assign jmp_target = PC_W'(ir_q[11:0]);

    assign rs_val = (R0_ZERO && rs_idx == 4'd0) ? '0 : rf_q[rs_idx];
    assign rt_val = (R0_ZERO && rt_idx == 4'd0) ? '0 : rf_q[rt_idx];

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a
        // default first, so no path leaves it unassigned and no latch is inferred.
        alu_b   = use_imm ? imm_ext : b_q;
        alu_res = a_q + alu_b;
        case (op)
            OP_SUB, OP_BEQ: alu_res = a_q - alu_b;
            OP_XOR:         alu_res = a_q ^ alu_b;
            OP_OR:          alu_res = a_q | alu_b;
            OP_AND:         alu_res = a_q & alu_b;
            OP_SLT:         alu_res = ($signed(a_q) < $signed(alu_b)) ? DATA_W'(1) : '0;
            default:        alu_res = a_q + alu_b;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (imem_ack) state_d = S_DECODE;
            S_DECODE: begin
                if (is_nop)       state_d = S_FETCH;
                else if (is_halt) state_d = S_HALT;
                else              state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_lw || is_sw)     state_d = S_MEM;
                else if (is_j || is_beq) state_d = S_FETCH;
                else                     state_d = S_WB;
            end
            S_MEM: begin
                if (dmem_ack) state_d = is_sw ? S_FETCH : S_WB;
            end
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Requests are masked during reset so a pending
    // handshake is dropped in the reset cycle itself.
    // ------------------------------------------------------------------
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        halted   = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: imem_req = 1'b1;
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = is_sw;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign imem_addr  = pc_q;
    assign dmem_addr  = alu_q[DADDR_W-1:0];
    assign dmem_wdata = b_q;
    assign pc         = pc_q;
    assign alu_out    = alu_q;
    assign retire     = retire_q;

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        ir_d     = ir_q;
        pc_d     = pc_q;
        a_d      = a_q;
        b_d      = b_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        retire_d = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d = imem_rdata;
                    pc_d = pc_q + PC_W'(2);
                end
            end
            S_DECODE: begin
                a_d      = rs_val;
                b_d      = rt_val;
                retire_d = is_nop;
            end
            S_EXEC: begin
                alu_d = alu_res;
                if (is_j) begin
                    pc_d     = jmp_target;
                    retire_d = 1'b1;
                end else if (is_beq) begin
                    // pc already points past the BEQ, so the offset is
                    // relative to the following instruction.
                    if (a_q == b_q) pc_d = pc_q + br_off;
                    retire_d = 1'b1;
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (is_lw) mdr_d = dmem_rdata;
                    else       retire_d = 1'b1;
                end
            end
            S_WB:    retire_d = 1'b1;
            default: ;
        endcase
    end

    // Register file write port, active only in WB.
    assign rf_we = (state_q == S_WB) && !(R0_ZERO && rd_idx == 4'd0);

    always_comb begin
        rf_d = rf_q;
        if (rf_we) rf_d[rd_idx] = is_lw ? mdr_q : alu_q;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q     <= '0;
            pc_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            alu_q    <= '0;
            mdr_q    <= '0;
            retire_q <= 1'b0;
        end else begin
            ir_q     <= ir_d;
            pc_q     <= pc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            alu_q    <= alu_d;
            mdr_q    <= mdr_d;
            retire_q <= retire_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the register file is built from flops rather than a RAM
            // macro, because r1..r5 must come out of reset holding 1..5.
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= (i >= 1 && i <= 5) ? DATA_W'(i) : '0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

endmodule

// File: tb/tb_mips16_multicycle_core.sv
// ---------------------------------------------------------------------------
// tb_mips16_multicycle_core
//
// Directed bench for mips16_multicycle_core. Behavioural instruction and data
// memories answer the req/ack handshakes with a programmable number of wait
// cycles. Register contents are observed through later stores and alu_out.
// ---------------------------------------------------------------------------
module tb_mips16_multicycle_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [5:0]  dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_ack;
    logic [15:0] dmem_rdata;
    logic [15:0] pc;
    logic [15:0] alu_out;
    logic        retire;
    logic        halted;

    mips16_multicycle_core dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .pc         (pc),
        .alu_out    (alu_out),
        .retire     (retire),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [15:0] imem [64];
    logic [15:0] dmem [64];
    int          imem_wait;
    int          dmem_wait;
    logic [5:0]  st_addr;
    logic [15:0] st_data;
    logic [5:0]  ld_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Memory responders: decide ack on the falling edge, away from the
    // rising edge where the core samples it.
    initial begin
        int icnt;
        int dcnt;
        icnt = 0;
        dcnt = 0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                if (icnt >= imem_wait) begin
                    imem_ack   = 1'b1;
                    imem_rdata = imem[imem_addr[6:1]];
                    icnt       = 0;
                end else begin
                    imem_ack = 1'b0;
                    icnt++;
                end
            end else begin
                imem_ack = 1'b0;
                icnt     = 0;
            end
            if (dmem_req) begin
                if (dcnt >= dmem_wait) begin
                    dmem_ack = 1'b1;
                    dcnt     = 0;
                    if (dmem_we) begin
                        dmem[dmem_addr] = dmem_wdata;
                        st_addr         = dmem_addr;
                        st_data         = dmem_wdata;
                    end else begin
                        dmem_rdata = dmem[dmem_addr];
                        ld_addr    = dmem_addr;
                    end
                end else begin
                    dmem_ack = 1'b0;
                    dcnt++;
                end
            end else begin
                dmem_ack = 1'b0;
                dcnt     = 0;
            end
        end
    end

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = 16'hB000;
    endtask

    // Counts rising edges until retire is seen; the start point is a cycle
    // in which a fetch has just begun.
    task automatic step(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (retire) break;
        end
        check({tag, "_lat"}, n, exp_lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int reqs;
        int rets;
        rst       = 1'b1;
        imem_wait = 0;
        dmem_wait = 0;
        st_addr   = '0;
        st_data   = '0;
        ld_addr   = '0;
        for (int i = 0; i < 64; i++) dmem[i] = '0;

        // Program A: arithmetic, memory, control flow
        clear_imem();
        imem[0]  = 16'h0312; // ADD  r3,r1,r2
        imem[1]  = 16'h1612; // SUB  r6,r1,r2
        imem[2]  = 16'h275F; // ADDI r7,r5,-1
        imem[3]  = 16'h4421; // SW   r4,1(r2)
        imem[4]  = 16'h3821; // LW   r8,1(r2)
        imem[5]  = 16'h4380; // SW   r3,0(r8)
        imem[6]  = 16'h4760; // SW   r7,0(r6)
        imem[7]  = 16'hA961; // SLT  r9,r6,r1
        imem[8]  = 16'h6B53; // XOR  r11,r5,r3
        imem[9]  = 16'h7C53; // OR   r12,r5,r3
        imem[10] = 16'h9D53; // AND  r13,r5,r3
        imem[11] = 16'hB000; // NOP
        imem[12] = 16'h5020; // J    0x020
        imem[16] = 16'h812E; // BEQ  r1,r2,-2 (not taken)
        imem[17] = 16'h8113; // BEQ  r1,r1,+3 (taken -> 0x2A)

        repeat (2) @(posedge clk);
        #1;
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_dmem_req", dmem_req, 1'b0);
        check("rst_retire",   retire,   1'b0);
        check("rst_halted",   halted,   1'b0);
        check("rst_pc",       pc,       16'h0000);
        check("rst_alu_out",  alu_out,  16'h0000);
        rst = 1'b0;

        step("add", 4);
        check("add_alu", alu_out, 16'h0003);
        check("add_pc",  pc,      16'h0002);

        // Fetch with three wait cycles: request and address must hold.
        imem_wait = 3;
        for (int k = 0; k < 4; k++) begin
            check("sub_wait_req",  imem_req,  1'b1);
            check("sub_wait_addr", imem_addr, 16'h0002);
            if (k < 3) begin
                @(posedge clk);
                #1;
            end
        end
        step("sub", 4);
        imem_wait = 0;
        check("sub_alu", alu_out, 16'hFFFF);
        check("sub_pc",  pc,      16'h0004);

        step("addi", 4);
        check("addi_alu", alu_out, 16'h0004);

        step("sw", 4);
        check("sw_addr", st_addr, 6'd3);
        check("sw_data", st_data, 16'h0004);

        step("lw", 5);
        check("lw_addr", ld_addr, 6'd3);
        check("lw_alu",  alu_out, 16'h0003);

        step("sw_r3", 4);
        check("sw_r3_addr", st_addr, 6'd4);
        check("sw_r3_data", st_data, 16'h0003);

        step("sw_r7", 4);
        check("sw_r7_addr", st_addr, 6'd63);
        check("sw_r7_data", st_data, 16'h0004);

        step("slt", 4);
        check("slt_alu", alu_out, 16'h0001);
        step("xor", 4);
        check("xor_alu", alu_out, 16'h0006);
        step("or", 4);
        check("or_alu",  alu_out, 16'h0007);
        step("and", 4);
        check("and_alu", alu_out, 16'h0001);

        step("nop", 2);
        check("nop_pc", pc, 16'h0018);
        step("j", 3);
        check("j_pc", pc, 16'h0020);
        step("beq_nt", 3);
        check("beq_nt_pc", pc, 16'h0022);
        step("beq_t", 3);
        check("beq_t_pc", pc, 16'h002A);

        // Program B: spec branch, then reset during a stalled load
        rst = 1'b1;
        clear_imem();
        imem[0] = 16'h5006; // J   0x006
        imem[3] = 16'h811E; // BEQ r1,r1,-2 -> 0x004
        imem[2] = 16'h3821; // LW  r8,1(r2)
        @(posedge clk);
        #1;
        rst = 1'b0;

        step("b_j", 3);
        check("b_j_pc", pc, 16'h0006);
        step("b_beq", 3);
        check("b_beq_pc", pc, 16'h0004);

        dmem_wait = 1000;
        repeat (5) @(posedge clk);
        #1;
        check("lw_wait_req",  dmem_req,  1'b1);
        check("lw_wait_we",   dmem_we,   1'b0);
        check("lw_wait_addr", dmem_addr, 6'd3);
        check("lw_wait_ret",  retire,    1'b0);

        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_pc",       pc,       16'h0000);
        check("mid_rst_alu",      alu_out,  16'h0000);
        check("mid_rst_retire",   retire,   1'b0);
        check("mid_rst_halted",   halted,   1'b0);
        check("mid_rst_imem_req", imem_req, 1'b0);
        check("mid_rst_dmem_req", dmem_req, 1'b0);
        dmem_wait = 0;

        // Program C: register reset values, jump, halt
        clear_imem();
        imem[0] = 16'h4700; // SW   r7,0(r0)
        imem[1] = 16'h5010; // J    0x010
        imem[8] = 16'hF000; // HALT
        rst = 1'b0;
        #1;
        check("post_rst_req",  imem_req,  1'b1);
        check("post_rst_addr", imem_addr, 16'h0000);

        step("c_sw", 4);
        check("c_sw_addr", st_addr, 6'd0);
        check("c_sw_data", st_data, 16'h0000);
        step("c_j", 3);
        check("c_j_pc", pc, 16'h0010);

        repeat (2) @(posedge clk);
        #1;
        check("halt_halted", halted, 1'b1);
        reqs = 0;
        rets = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (imem_req) reqs++;
            if (retire)   rets++;
        end
        check("halt_no_req",    reqs,   0);
        check("halt_no_retire", rets,   0);
        check("halt_stays",     halted, 1'b1);
        check("halt_pc",        pc,     16'h0012);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
